// File: rtl/fusion_mac_array_if.sv
// Handshake and operand bus for fusion_mac_array.
// slave  : the MAC array side (consumes beats, produces results)
// master : the producer/consumer side (operand buffers and writeback)
interface fusion_mac_array_if #(
   parameter int unsigned NLANE = 4,
   parameter int unsigned ACC_W = 32
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [8*NLANE-1:0]   in_a;
   logic [8*NLANE-1:0]   in_b;
   logic [1:0]           cfga;
   logic [1:0]           cfgb;
   logic                 sa;
   logic                 sb;
   logic                 in_first;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [ACC_W-1:0]     out_acc;
   logic                 out_ovf;
   logic                 cfg_err;

   modport slave (
      input  in_valid, in_a, in_b, cfga, cfgb, sa, sb, in_first, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_ovf, cfg_err
   );

   modport master (
      output in_valid, in_a, in_b, cfga, cfgb, sa, sb, in_first, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_ovf, cfg_err
   );
endinterface

// File: rtl/fusion_mac_array.sv
// Bit-fusion dot-product engine. NLANE lanes of packed 8-bit a/b words, per-beat
// precision (8/4/2 bit) and signedness. Three stages: S1 operand register, S2
// product/tree-sum register, S3 accumulator + result register. Whole pipe stalls
// together while a finished result waits for the consumer.
// Optional build macro: FUSION_MAC_SAT_EN -- saturating accumulator and out_ovf.
module fusion_mac_array #(
   parameter int unsigned NLANE = 4,
   parameter int unsigned ACC_W = 32
) (
   input logic               clk,
   input logic               rst,
   fusion_mac_array_if.slave bus
);
   localparam int unsigned LANE_W = 20;
   localparam int unsigned SUM_W  = LANE_W + $clog2(NLANE);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StHold = 2'd2;

   generate
      if (ACC_W < SUM_W) begin : g_acc_w_check
         $error("fusion_mac_array: ACC_W must be >= 20 + clog2(NLANE)");
      end
   endgenerate

   // Extract element k of a packed word at the given precision, extended to 9b signed.
   function automatic logic signed [8:0] elem(input logic [7:0] w, input logic [1:0] cfg,
                                              input logic [1:0] k, input logic sgn);
      logic [3:0] nib;
      logic [1:0] crumb;
      nib   = w[{k[0], 2'b00} +: 4];
      crumb = w[{k, 1'b0} +: 2];
      case (cfg)
         2'b10:   elem = {sgn & w[7], w};
         2'b01:   elem = {{5{sgn & nib[3]}}, nib};
         default: elem = {{7{sgn & crumb[1]}}, crumb};
      endcase
   endfunction

   logic adv;
   logic out_valid;

   // S1 state
   logic               s1_valid_q;
   logic [8*NLANE-1:0] s1_a_q;
   logic [8*NLANE-1:0] s1_b_q;
   logic [1:0]         s1_cfga_q;
   logic [1:0]         s1_cfgb_q;
   logic               s1_sa_q;
   logic               s1_sb_q;
   logic               s1_first_q;
   logic               s1_last_q;
   logic               cfg_err_q;

   // S2 state
   logic                    s2_valid_q;
   logic signed [SUM_W-1:0] s2_sum_q;
   logic                    s2_first_q;
   logic                    s2_last_q;

   // S3 state
   logic [1:0]              state_q;
   logic [1:0]              state_d;
   logic [1:0]              state_eff;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] beat_sum;

   // Tree-sum datapath
   logic                     illegal;
   logic [1:0]               pmax;
   logic signed [8:0]        ea;
   logic signed [8:0]        eb;
   logic signed [17:0]       prod;
   logic signed [LANE_W-1:0] lane_acc;
   logic signed [SUM_W-1:0]  tree_sum;

   // A held result blocks every stage; nothing moves until it is taken.
   assign out_valid    = (state_q == StHold);
   assign adv          = !out_valid || bus.out_ready;
   assign bus.in_ready = adv;

   // S1: capture the accepted beat together with its config.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_cfga_q  <= 2'b10;
         s1_cfgb_q  <= 2'b10;
         s1_sa_q    <= 1'b0;
         s1_sb_q    <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
      end else if (adv) begin
         s1_valid_q <= bus.in_valid;
         s1_a_q     <= bus.in_a;
         s1_b_q     <= bus.in_b;
         s1_cfga_q  <= bus.cfga;
         s1_cfgb_q  <= bus.cfgb;
         s1_sa_q    <= bus.sa;
         s1_sb_q    <= bus.sb;
         s1_first_q <= bus.in_first;
         s1_last_q  <= bus.in_last;
      end
   end

   // Sticky flag: any accepted beat with an illegal precision code on either side.
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_err_q <= 1'b0;
      end else if (bus.in_valid && adv && ((bus.cfga == 2'b11) || (bus.cfgb == 2'b11))) begin
         cfg_err_q <= 1'b1;
      end
   end

   // Products and cross-lane sum of the beat sitting in S1.
   always_comb begin
      illegal  = (s1_cfga_q == 2'b11) || (s1_cfgb_q == 2'b11);
      // Larger code = wider element; the wider side sets the pair count K.
      pmax     = (s1_cfga_q > s1_cfgb_q) ? s1_cfga_q : s1_cfgb_q;
      ea       = '0;
      eb       = '0;
      prod     = '0;
      lane_acc = '0;
      tree_sum = '0;
      for (int i = 0; i < NLANE; i++) begin
         lane_acc = '0;
         for (int k = 0; k < 4; k++) begin
            // Pair k is live when k < K (K = 1, 2, 4 for 8, 4, 2 bit).
            if (!illegal && ((pmax == 2'b00) || ((pmax == 2'b01) && (k < 2)) || (k == 0))) begin
               ea       = elem(s1_a_q[8*i +: 8], s1_cfga_q, k[1:0], s1_sa_q);
               eb       = elem(s1_b_q[8*i +: 8], s1_cfgb_q, k[1:0], s1_sb_q);
               prod     = 18'(ea) * 18'(eb);
               lane_acc = lane_acc + LANE_W'(prod);
            end
         end
         tree_sum = tree_sum + SUM_W'(lane_acc);
      end
   end

   // S2: register the beat sum and its framing bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_sum_q   <= '0;
         s2_first_q <= 1'b0;
         s2_last_q  <= 1'b0;
      end else if (adv) begin
         s2_valid_q <= s1_valid_q;
         s2_sum_q   <= tree_sum;
         s2_first_q <= s1_first_q;
         s2_last_q  <= s1_last_q;
      end
   end

   assign beat_sum = ACC_W'(s2_sum_q);

`ifdef FUSION_MAC_SAT_EN
   localparam int unsigned WIDE_W = ACC_W + 1;
   localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [WIDE_W-1:0] wide;
   logic                     ovf_q;
   logic                     ovf_d;
`endif

   // Accumulator FSM: a beat reaching S3 opens, extends or closes a dot product.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      // Handing off a held result frees S3 on the same edge.
      state_eff = (state_q == StHold) ? StIdle : state_q;
`ifdef FUSION_MAC_SAT_EN
      ovf_d     = ovf_q;
      wide      = WIDE_W'(acc_q) + WIDE_W'(beat_sum);
`endif
      if (adv) begin
         state_d = state_eff;
         if (s2_valid_q) begin
            if ((state_eff == StIdle) || s2_first_q) begin
               acc_d = beat_sum;
`ifdef FUSION_MAC_SAT_EN
               ovf_d = 1'b0;
`endif
            end else begin
`ifdef FUSION_MAC_SAT_EN
               // Sign bits disagree only when the add left the ACC_W range.
               if (wide[WIDE_W-1] != wide[WIDE_W-2]) begin
                  acc_d = wide[WIDE_W-1] ? AccMin : AccMax;
                  ovf_d = 1'b1;
               end else begin
                  acc_d = wide[ACC_W-1:0];
               end
`else
               acc_d = acc_q + beat_sum;
`endif
            end
            state_d = s2_last_q ? StHold : StRun;
         end
      end
   end

   // S3: accumulator, FSM state and overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         acc_q   <= '0;
`ifdef FUSION_MAC_SAT_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
`ifdef FUSION_MAC_SAT_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign bus.out_valid = out_valid;
   assign bus.out_acc   = acc_q;
   assign bus.cfg_err   = cfg_err_q;
`ifdef FUSION_MAC_SAT_EN
   assign bus.out_ovf   = ovf_q;
`else
   assign bus.out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_fusion_mac_array.sv
// Scoreboard bench for fusion_mac_array: directed beats push expected results,
// per-DUT monitors pop and compare on every output transfer.
// Second instance (NLANE=1, ACC_W=20) covers the accumulator wrap/saturation edge.
module tb_fusion_mac_array;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fusion_mac_array_if #(.NLANE(4), .ACC_W(32)) bus ();
   fusion_mac_array_if #(.NLANE(1), .ACC_W(20)) bus1 ();

   fusion_mac_array #(.NLANE(4), .ACC_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   fusion_mac_array #(.NLANE(1), .ACC_W(20)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   typedef struct packed {
      logic [31:0] acc;
      logic        ovf;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp1_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push(input logic [31:0] acc, input logic ovf);
      exp_t e;
      e.acc = acc;
      e.ovf = ovf;
      exp_q.push_back(e);
   endtask

   // Present one beat on the 4-lane DUT and hold it until accepted.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ca,
                       input logic [1:0] cb, input logic s_a, input logic s_b,
                       input logic first, input logic last);
      int n;
      n = 0;
      @(negedge clk);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.cfga     = ca;
      bus.cfgb     = cb;
      bus.sa       = s_a;
      bus.sb       = s_b;
      bus.in_first = first;
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("send_accept", 64'(bus.in_ready), 64'd1);
      if (bus.in_ready) begin
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(exp_q.size() + exp1_q.size()), 64'd0);
   endtask

   // Monitor for the 4-lane DUT: every output transfer must match the queue head.
   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: got acc 0x%0h, expected no result", bus.out_acc);
         end else begin
            e = exp_q.pop_front();
            check("out_acc", 64'(bus.out_acc), 64'(e.acc));
            check("out_ovf", 64'(bus.out_ovf), 64'(e.ovf));
         end
      end
   end

   // Monitor for the narrow DUT.
   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (!rst && bus1.out_valid && bus1.out_ready) begin
         if (exp1_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out1: got acc 0x%0h, expected no result", bus1.out_acc);
         end else begin
            e = exp1_q.pop_front();
            check("out_acc1", 64'(bus1.out_acc), 64'(e.acc));
            check("out_ovf1", 64'(bus1.out_ovf), 64'(e.ovf));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e1;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      bus.cfga     = 2'b10;
      bus.cfgb     = 2'b10;
      bus.sa       = 1'b0;
      bus.sb       = 1'b0;
      bus.in_first = 1'b0;
      bus.in_last  = 1'b0;
      bus.out_ready = 1'b1;
      bus1.in_valid = 1'b0;
      bus1.in_a     = '0;
      bus1.in_b     = '0;
      bus1.cfga     = 2'b10;
      bus1.cfgb     = 2'b10;
      bus1.sa       = 1'b1;
      bus1.sb       = 1'b1;
      bus1.in_first = 1'b0;
      bus1.in_last  = 1'b0;
      bus1.out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_acc", 64'(bus.out_acc), 64'd0);
      check("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
      check("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // 8x8 signed, single beat; result visible two edges after acceptance
      push(32'd16268, 1'b0);
      send(32'h807F_0102, 32'h80FF_0503, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
      check("lat_e0", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
      check("lat_e1", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
      check("lat_e2", 64'(bus.out_valid), 64'd1);
      check("lat_acc", 64'(bus.out_acc), 64'd16268);
      drain("drain_t1");

      // 2x2 unsigned then signed, lane0 all ones
      push(32'd36, 1'b0);
      send(32'h0000_00FF, 32'h0000_00FF, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      push(32'd4, 1'b0);
      send(32'h0000_00FF, 32'h0000_00FF, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1);

      // 8x4 mixed signedness, then an illegal-config beat contributing 0
      push(32'hFFFF_FF90, 1'b0);
      send(32'h0000_0010, 32'h0000_00A9, 2'b10, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
      drain("drain_t3");
      check("cfg_err_clear", 64'(bus.cfg_err), 64'd0);
      push(32'd0, 1'b0);
      send(32'h1234_5678, 32'h1111_1111, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
      drain("drain_t3b");
      check("cfg_err_set", 64'(bus.cfg_err), 64'd1);

      // Multi-beat with an in_first mid-run discarding the partial sum: 3 + 4
      push(32'd7, 1'b0);
      send(32'd10, 32'd1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
      send(32'd3, 32'd1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
      send(32'd4, 32'd1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
      drain("drain_restart");

      // Back-to-back results against a stalled consumer
      @(negedge clk);
      bus.out_ready = 1'b0;
      push(32'd1, 1'b0);
      push(32'd6, 1'b0);
      push(32'd63, 1'b0);
      send(32'd1, 32'd1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
      send(32'd2, 32'd3, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
      send(32'd7, 32'd9, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_acc", 64'(bus.out_acc), 64'd1);
      @(negedge clk);
      bus.out_ready = 1'b1;
      drain("drain_stall");

      // Reset in the middle of a four-beat product
      send(32'd1, 32'd1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
      send(32'd2, 32'd2, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_acc", 64'(bus.out_acc), 64'd0);
      check("mid_rst_ovf", 64'(bus.out_ovf), 64'd0);
      check("mid_rst_cfg_err", 64'(bus.cfg_err), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      push(32'd25, 1'b0);
      send(32'd5, 32'd5, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
      drain("drain_rst");

      // Narrow accumulator: 32 beats of (-128)*(-128) = 2^19 total
`ifdef FUSION_MAC_SAT_EN
      e1.acc = 32'h0007_FFFF;
      e1.ovf = 1'b1;
`else
      e1.acc = 32'h0008_0000;
      e1.ovf = 1'b0;
`endif
      exp1_q.push_back(e1);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         bus1.in_a     = 8'h80;
         bus1.in_b     = 8'h80;
         bus1.in_first = (i == 0);
         bus1.in_last  = (i == 31);
         bus1.in_valid = 1'b1;
      end
      check("narrow_in_ready", 64'(bus1.in_ready), 64'd1);
      @(negedge clk);
      bus1.in_valid = 1'b0;
      drain("drain_narrow");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
